// File: rtl/rst_seq_gen_pkg.sv
// Shared types and helpers for the multi-channel reset sequencer.
// Optional watchdog is enabled by defining RST_SEQ_WDT_EN.
package rst_seq_gen_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } seq_state_t;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_gen_sync_ff.sv
// Multi-stage single-bit synchroniser with async active-low clear.
// Output is taken straight from the last flop.
module sync_ff #(
  parameter int STG = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STG-1:0] r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= '0;
    else        r <= {r[STG-2:0], d};
  end

  assign q = r[STG-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: async assert, ordered sync release.
// Define RST_SEQ_WDT_EN to add the RUN-state watchdog re-sequence.
module rst_seq_gen
  import rst_seq_gen_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int HOLD_CYC = 50,
  parameter int STEP_CYC = 25,
  parameter int SYNC_STG = 2,
  parameter int WDT_CYC  = 25000000
) (
  input  logic            clk_25m,
  input  logic            rst_n,
  input  logic            pll_locked,
  input  logic            soft_rst,
  input  logic            wdt_kick,
  output logic [N_CH-1:0] rst_n_out,
  output logic            rst_done,
  output logic            wdt_fired
);

  localparam int CW = clog2_f(
    max3(HOLD_CYC, STEP_CYC * N_CH, WDT_CYC) + 1);
  localparam int IW = clog2_f(N_CH);

  localparam logic [CW-1:0] HOLD_L = CW'(HOLD_CYC);
  localparam logic [CW-1:0] STEP_L = CW'(STEP_CYC - 1);
  localparam logic [IW-1:0] LAST_L = IW'(N_CH - 1);

  logic       rst_sync;
  logic       lock_sync;
  logic       soft_q;
  logic       soft_rise;
  logic       lock_lost;
  logic       wdt_hit;
  logic       trig;
  seq_state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  sync_ff #(.STG(SYNC_STG)) u_rst_sync (
    .clk   (clk_25m),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_sync)
  );

  sync_ff #(.STG(SYNC_STG)) u_lock_sync (
    .clk   (clk_25m),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_sync)
  );

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) soft_q <= 1'b0;
    else        soft_q <= soft_rst;
  end

  assign soft_rise = soft_rst & ~soft_q;
  assign lock_lost = ~lock_sync &
                     (state == S_RELEASE || state == S_RUN);
  assign trig      = soft_rise | lock_lost | wdt_hit;

`ifdef RST_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_L = CW'(WDT_CYC - 1);

  // A kick on the terminal cycle still wins over the timeout.
  assign wdt_hit = (state == S_RUN) & ~wdt_kick & (cnt == WDT_L);

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n)       wdt_fired <= 1'b0;
    else if (wdt_hit) wdt_fired <= 1'b1;
  end
`else
  logic unused_kick;

  assign unused_kick = wdt_kick;
  assign wdt_hit     = 1'b0;
  assign wdt_fired   = 1'b0;
`endif

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      rst_done  <= 1'b0;
    end else if (!rst_sync || trig) begin
      state     <= S_HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      rst_done  <= 1'b0;
    end else begin
      unique case (state)
        S_HOLD: begin
          if (cnt == HOLD_L) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_sync) begin
            state <= S_RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        S_RELEASE: begin
          if (cnt == STEP_L) begin
            rst_n_out[idx] <= 1'b1;
            cnt            <= '0;
            if (idx == LAST_L) begin
              state    <= S_RUN;
              rst_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
`ifdef RST_SEQ_WDT_EN
          if (wdt_kick) cnt <= '0;
          else          cnt <= cnt + 1'b1;
`endif
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
